// File: rtl/ps2_line_buffer.sv
// Line-assembly stage: turns cleaned ASCII keystrokes into a 32-character edit line.
// Enter publishes the line with a one-cycle ready strobe. Each edit produces an echo write.
module ps2_line_buffer #(
  parameter int unsigned LINE_CHARS = 32,
  parameter logic [7:0]  PAD_CHAR   = 8'h20
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [7:0]              input_character,
  input  logic                    input_made,
  output logic [8*LINE_CHARS-1:0] ps2_line_content,
  output logic                    ps2_line_ready,
  output logic [8*LINE_CHARS-1:0] edit_content,
  output logic [5:0]              cursor,
  output logic                    line_full,
  output logic                    overflow,
  output logic                    echo_write,
  output logic [4:0]              echo_col,
  output logic [7:0]              echo_char
);

  localparam logic [5:0] FullCount = 6'(LINE_CHARS);

  logic                    r_made;
  logic [7:0]              r_buf [LINE_CHARS];
  logic [8*LINE_CHARS-1:0] r_line;
  logic                    r_ready;
  logic [5:0]              r_cursor;
  logic                    r_overflow;
  logic                    r_echo_write;
  logic [4:0]              r_echo_col;
  logic [7:0]              r_echo_char;

  logic                    w_key_evt;
  logic                    w_is_print;
  logic                    w_is_bksp;
  logic                    w_is_enter;
  logic                    w_full;
  logic                    w_empty;
  logic [5:0]              w_cursor_dec;
  logic [8*LINE_CHARS-1:0] w_edit;

  always_comb begin
    w_key_evt    = input_made & ~r_made;
    w_is_print   = (input_character >= 8'h20) && (input_character <= 8'h7e);
    w_is_bksp    = (input_character == 8'h08);
    w_is_enter   = (input_character == 8'h0d) || (input_character == 8'h0a);
    w_full       = (r_cursor == FullCount);
    w_empty      = (r_cursor == 6'd0);
    w_cursor_dec = r_cursor - 6'd1;
  end

  // Char 0 occupies the most significant byte.
  always_comb begin
    w_edit = '0;
    for (int unsigned i = 0; i < LINE_CHARS; i++) begin
      w_edit[8*(LINE_CHARS-1-i) +: 8] = r_buf[i];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_made       <= 1'b0;
      r_line       <= {LINE_CHARS{PAD_CHAR}};
      r_ready      <= 1'b0;
      r_cursor     <= 6'd0;
      r_overflow   <= 1'b0;
      r_echo_write <= 1'b0;
      r_echo_col   <= 5'd0;
      r_echo_char  <= 8'h00;
      for (int unsigned i = 0; i < LINE_CHARS; i++) begin
        r_buf[i] <= PAD_CHAR;
      end
    end else begin
      r_made       <= input_made;
      r_ready      <= 1'b0;
      r_echo_write <= 1'b0;
      if (w_key_evt) begin
        if (w_is_print) begin
          if (!w_full) begin
            r_buf[r_cursor[4:0]] <= input_character;
            r_cursor             <= r_cursor + 6'd1;
            r_echo_write         <= 1'b1;
            r_echo_col           <= r_cursor[4:0];
            r_echo_char          <= input_character;
          end else begin
            r_overflow <= 1'b1;
          end
        end else if (w_is_bksp) begin
          if (!w_empty) begin
            r_buf[w_cursor_dec[4:0]] <= PAD_CHAR;
            r_cursor                 <= w_cursor_dec;
            r_echo_write             <= 1'b1;
            r_echo_col               <= w_cursor_dec[4:0];
            r_echo_char              <= PAD_CHAR;
          end
        end else if (w_is_enter) begin
          // Slots at or beyond the cursor are always pad, so the buffer commits as-is.
          if (!w_empty) begin
            r_line     <= w_edit;
            r_ready    <= 1'b1;
            r_cursor   <= 6'd0;
            r_overflow <= 1'b0;
            for (int unsigned i = 0; i < LINE_CHARS; i++) begin
              r_buf[i] <= PAD_CHAR;
            end
          end
        end
      end
    end
  end

  assign ps2_line_content = r_line;
  assign ps2_line_ready   = r_ready;
  assign edit_content     = w_edit;
  assign cursor           = r_cursor;
  assign line_full        = w_full;
  assign overflow         = r_overflow;
  assign echo_write       = r_echo_write;
  assign echo_col         = r_echo_col;
  assign echo_char        = r_echo_char;

endmodule

// File: tb/tb_ps2_line_buffer.sv
// Self-checking bench for ps2_line_buffer: directed scenarios plus randomized keystrokes
// compared against a queue-based model of the line.
module tb_ps2_line_buffer;

  logic         clock = 1'b0;
  logic         resetn;
  logic [7:0]   input_character;
  logic         input_made;
  logic [255:0] ps2_line_content;
  logic         ps2_line_ready;
  logic [255:0] edit_content;
  logic [5:0]   cursor;
  logic         line_full;
  logic         overflow;
  logic         echo_write;
  logic [4:0]   echo_col;
  logic [7:0]   echo_char;

  always #5 clock = ~clock;

  ps2_line_buffer dut (
    .clock            (clock),
    .resetn           (resetn),
    .input_character  (input_character),
    .input_made       (input_made),
    .ps2_line_content (ps2_line_content),
    .ps2_line_ready   (ps2_line_ready),
    .edit_content     (edit_content),
    .cursor           (cursor),
    .line_full        (line_full),
    .overflow         (overflow),
    .echo_write       (echo_write),
    .echo_col         (echo_col),
    .echo_char        (echo_char)
  );

  localparam logic [255:0] AllPad = {32{8'h20}};

  int checks   = 0;
  int failures = 0;

  // Reference model of the line.
  logic [7:0]   q_line [$];
  logic         m_ovf = 1'b0;
  logic [255:0] m_committed = AllPad;
  int           exp_echo = 0;
  int           exp_ready = 0;
  logic [4:0]   m_echo_col = 5'd0;
  logic [7:0]   m_echo_char = 8'h00;

  // Pulse monitor, sampled mid-cycle.
  int           echo_cnt = 0;
  int           ready_cnt = 0;
  int           both_cnt = 0;
  logic [4:0]   mon_col = 5'd0;
  logic [7:0]   mon_char = 8'h00;
  logic [255:0] mon_line = AllPad;

  always @(negedge clock) begin
    if (resetn) begin
      if (echo_write) begin
        echo_cnt++;
        mon_col  = echo_col;
        mon_char = echo_char;
      end
      if (ps2_line_ready) begin
        ready_cnt++;
        mon_line = ps2_line_content;
      end
      if (echo_write && ps2_line_ready) both_cnt++;
    end
  end

  function automatic logic [255:0] model_edit();
    logic [255:0] r;
    r = AllPad;
    for (int i = 0; i < q_line.size(); i++) r[255-8*i -: 8] = q_line[i];
    return r;
  endfunction

  task automatic model_key(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7e) begin
      if (q_line.size() < 32) begin
        m_echo_col  = 5'(q_line.size());
        m_echo_char = ch;
        q_line.push_back(ch);
        exp_echo++;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (ch == 8'h08) begin
      if (q_line.size() > 0) begin
        void'(q_line.pop_back());
        m_echo_col  = 5'(q_line.size());
        m_echo_char = 8'h20;
        exp_echo++;
      end
    end else if (ch == 8'h0d || ch == 8'h0a) begin
      if (q_line.size() > 0) begin
        m_committed = model_edit();
        exp_ready++;
        q_line.delete();
        m_ovf = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    q_line.delete();
    m_ovf       = 1'b0;
    m_committed = AllPad;
    m_echo_col  = 5'd0;
    m_echo_char = 8'h00;
  endtask

  // Called at a falling edge; returns at a falling edge with input_made low.
  task automatic press(input logic [7:0] ch, input int hold);
    input_character = ch;
    input_made      = 1'b1;
    model_key(ch);
    repeat (hold) @(negedge clock);
    input_made = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    resetn          = 1'b0;
    input_made      = 1'b0;
    input_character = 8'h00;
    repeat (2) @(negedge clock);
    checks++; if (ps2_line_content !== AllPad) begin failures++;
      $display("FAIL reset_line got=%h exp=%h", ps2_line_content, AllPad); end
    checks++; if (edit_content !== AllPad) begin failures++;
      $display("FAIL reset_edit got=%h exp=%h", edit_content, AllPad); end
    checks++; if ({ps2_line_ready, cursor, line_full, overflow} !== 9'd0) begin failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {ps2_line_ready, cursor, line_full, overflow}); end
    checks++; if ({echo_write, echo_col, echo_char} !== 14'd0) begin failures++;
      $display("FAIL reset_echo got=%h exp=0", {echo_write, echo_col, echo_char}); end
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (cursor !== 6'd0 || echo_cnt !== 0) begin failures++;
      $display("FAIL reset_idle cursor=%0d echoes=%0d exp 0/0", cursor, echo_cnt); end
  endtask

  task automatic test_typing();
    int e0, r0;
    e0 = echo_cnt; r0 = ready_cnt;
    input_character = 8'h41;
    input_made      = 1'b1;
    model_key(8'h41);
    @(posedge clock); #1;
    checks++; if ({echo_write, echo_col, echo_char, cursor} !== {1'b1, 5'd0, 8'h41, 6'd1}) begin
      failures++;
      $display("FAIL type_latency got we=%b col=%0d ch=%h cur=%0d exp 1/0/41/1",
               echo_write, echo_col, echo_char, cursor); end
    repeat (3) @(negedge clock);
    input_made = 1'b0;
    @(negedge clock);
    press(8'h42, 3);
    checks++; if (mon_col !== 5'd1 || mon_char !== 8'h42) begin failures++;
      $display("FAIL type_echo_b got col=%0d ch=%h exp 1/42", mon_col, mon_char); end
    press(8'h0d, 3);
    checks++; if (echo_cnt - e0 !== 2) begin failures++;
      $display("FAIL type_echo_count got=%0d exp=2", echo_cnt - e0); end
    checks++; if (ready_cnt - r0 !== 1) begin failures++;
      $display("FAIL type_ready_count got=%0d exp=1", ready_cnt - r0); end
    checks++; if (mon_line !== {8'h41, 8'h42, {30{8'h20}}}) begin failures++;
      $display("FAIL type_commit got=%h", mon_line); end
    checks++; if (cursor !== 6'd0 || edit_content !== AllPad) begin failures++;
      $display("FAIL type_cleared cursor=%0d edit=%h exp 0/pad", cursor, edit_content); end
  endtask

  task automatic test_held_key();
    int e0, r0;
    e0 = echo_cnt; r0 = ready_cnt;
    press(8'h5a, 10);
    checks++; if (echo_cnt - e0 !== 1 || cursor !== 6'd1) begin failures++;
      $display("FAIL held_key echoes=%0d cursor=%0d exp 1/1", echo_cnt - e0, cursor); end
    press(8'h0a, 1);
    checks++; if (ready_cnt - r0 !== 1 || mon_line !== {8'h5a, {31{8'h20}}}) begin failures++;
      $display("FAIL held_commit pulses=%0d line=%h", ready_cnt - r0, mon_line); end
  endtask

  task automatic test_backspace();
    int e0;
    e0 = echo_cnt;
    press(8'h58, 2);
    press(8'h59, 2);
    press(8'h08, 2);
    checks++; if (cursor !== 6'd1 || mon_col !== 5'd1 || mon_char !== 8'h20) begin failures++;
      $display("FAIL bksp_one cursor=%0d col=%0d ch=%h exp 1/1/20", cursor, mon_col, mon_char); end
    checks++; if (edit_content[255:240] !== 16'h5820) begin failures++;
      $display("FAIL bksp_edit got=%h exp=5820", edit_content[255:240]); end
    press(8'h08, 2);
    press(8'h08, 2);
    checks++; if (cursor !== 6'd0 || echo_cnt - e0 !== 4 || edit_content !== AllPad) begin
      failures++;
      $display("FAIL bksp_empty cursor=%0d echoes=%0d exp 0/4", cursor, echo_cnt - e0); end
  endtask

  task automatic test_overflow();
    int e0, r0;
    e0 = echo_cnt; r0 = ready_cnt;
    for (int i = 0; i < 33; i++) press(8'($urandom_range(32, 126)), 1);
    checks++; if ({cursor, line_full, overflow} !== {6'd32, 1'b1, 1'b1}) begin failures++;
      $display("FAIL ovf_state cursor=%0d full=%b ovf=%b exp 32/1/1", cursor, line_full, overflow); end
    checks++; if (echo_cnt - e0 !== 32) begin failures++;
      $display("FAIL ovf_echoes got=%0d exp=32", echo_cnt - e0); end
    checks++; if (edit_content !== model_edit()) begin failures++;
      $display("FAIL ovf_edit got=%h exp=%h", edit_content, model_edit()); end
    press(8'h08, 1);
    checks++; if (overflow !== 1'b1 || cursor !== 6'd31 || line_full !== 1'b0) begin failures++;
      $display("FAIL ovf_sticky ovf=%b cursor=%0d exp 1/31", overflow, cursor); end
    press(8'h7e, 1);
    press(8'h0d, 1);
    checks++; if (ready_cnt - r0 !== 1 || mon_line !== m_committed) begin failures++;
      $display("FAIL ovf_commit pulses=%0d line=%h exp=%h", ready_cnt - r0, mon_line,
               m_committed); end
    checks++; if (overflow !== 1'b0 || cursor !== 6'd0) begin failures++;
      $display("FAIL ovf_clear ovf=%b cursor=%0d exp 0/0", overflow, cursor); end
  endtask

  task automatic test_ignored();
    int e0, r0;
    logic [255:0] line0, edit0;
    logic [19:0]  misc0;
    e0 = echo_cnt; r0 = ready_cnt;
    line0 = ps2_line_content; edit0 = edit_content;
    misc0 = {cursor, overflow, echo_col, echo_char};
    press(8'h0d, 2);
    press(8'h1b, 2);
    checks++; if (ready_cnt - r0 !== 0 || echo_cnt - e0 !== 0) begin failures++;
      $display("FAIL ignored_pulses ready=%0d echo=%0d exp 0/0", ready_cnt - r0, echo_cnt - e0); end
    checks++; if (ps2_line_content !== line0 || edit_content !== edit0) begin failures++;
      $display("FAIL ignored_content line=%h edit=%h", ps2_line_content, edit_content); end
    checks++; if ({cursor, overflow, echo_col, echo_char} !== misc0) begin failures++;
      $display("FAIL ignored_misc got=%h exp=%h", {cursor, overflow, echo_col, echo_char}, misc0); end
  endtask

  task automatic test_reset_mid_line();
    press(8'h41, 2);
    press(8'h42, 2);
    press(8'h43, 2);
    @(posedge clock); #3;
    resetn = 1'b0;
    model_reset();
    #1;
    checks++; if (cursor !== 6'd0 || edit_content !== AllPad || ps2_line_content !== AllPad) begin
      failures++;
      $display("FAIL midreset_state cursor=%0d edit=%h line=%h", cursor, edit_content,
               ps2_line_content); end
    checks++; if ({ps2_line_ready, overflow, echo_write, echo_col, echo_char} !== 17'd0) begin
      failures++;
      $display("FAIL midreset_ctrl got=%h exp=0",
               {ps2_line_ready, overflow, echo_write, echo_col, echo_char}); end
    input_character = 8'h44;
    input_made      = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    model_key(8'h44);
    @(posedge clock); #1;
    checks++; if ({echo_write, echo_col, echo_char, cursor} !== {1'b1, 5'd0, 8'h44, 6'd1}) begin
      failures++;
      $display("FAIL midreset_first got we=%b col=%0d ch=%h cur=%0d exp 1/0/44/1",
               echo_write, echo_col, echo_char, cursor); end
    @(negedge clock);
    input_made = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [7:0] ch;
    int         sel;
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 70)      ch = 8'($urandom_range(32, 126));
      else if (sel < 85) ch = 8'h08;
      else if (sel < 88) ch = 8'h0d;
      else if (sel < 90) ch = 8'h0a;
      else if (sel < 95) ch = 8'($urandom_range(0, 31));
      else               ch = 8'($urandom_range(127, 255));
      press(ch, int'($urandom_range(1, 3)));
      checks++; if (cursor !== 6'(q_line.size()) || line_full !== (q_line.size() == 32)) begin
        failures++;
        $display("FAIL rand_cursor key=%0d got=%0d/%b exp=%0d", n, cursor, line_full,
                 q_line.size()); end
      checks++; if (edit_content !== model_edit()) begin failures++;
        $display("FAIL rand_edit key=%0d got=%h exp=%h", n, edit_content, model_edit()); end
      checks++; if (overflow !== m_ovf || ps2_line_content !== m_committed) begin failures++;
        $display("FAIL rand_line key=%0d ovf=%b exp=%b line=%h exp=%h", n, overflow, m_ovf,
                 ps2_line_content, m_committed); end
      checks++; if (mon_col !== m_echo_col || mon_char !== m_echo_char) begin failures++;
        $display("FAIL rand_echo key=%0d got=%0d/%h exp=%0d/%h", n, mon_col, mon_char,
                 m_echo_col, m_echo_char); end
    end
    checks++; if (echo_cnt !== exp_echo || ready_cnt !== exp_ready) begin failures++;
      $display("FAIL pulse_totals echo=%0d exp=%0d ready=%0d exp=%0d", echo_cnt, exp_echo,
               ready_cnt, exp_ready); end
    checks++; if (both_cnt !== 0) begin failures++;
      $display("FAIL echo_ready_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_typing();
    test_held_key();
    test_backspace();
    test_overflow();
    test_ignored();
    test_reset_mid_line();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
